// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use detection.
// Captures the decoded instruction and presents forwarded ALU operands to
// EX with no added latency. Also flags load-use hazards and inserts bubbles.
// Optional feature: define ID_EX_PERF_EN to build the saturating bubble
// counter. Without it, BUBBLE_COUNT is tied to zero and no counter exists.
module id_ex_stage (
    input  logic        CLK,
    input  logic        RESETN,
    input  logic        STALL,
    input  logic        FLUSH,
    input  logic        ID_VALID,
    input  logic [31:0] ID_PC,
    input  logic [31:0] ID_RS1_DATA,
    input  logic [31:0] ID_RS2_DATA,
    input  logic [31:0] ID_IMM,
    input  logic [4:0]  ID_RS1_ADDR,
    input  logic [4:0]  ID_RS2_ADDR,
    input  logic [4:0]  ID_RD_ADDR,
    input  logic [4:0]  ID_ALU_SELECT,
    input  logic [1:0]  ID_OP_SEL,
    input  logic [2:0]  ID_CTRL,
    input  logic        MEM_FWD_EN,
    input  logic [4:0]  MEM_FWD_RD,
    input  logic [31:0] MEM_FWD_DATA,
    output logic        EX_VALID,
    output logic [31:0] EX_PC,
    output logic [31:0] ALU_DATA1,
    output logic [31:0] ALU_DATA2,
    output logic [4:0]  ALU_SELECT,
    output logic [31:0] EX_STORE_DATA,
    output logic [4:0]  EX_RD_ADDR,
    output logic [2:0]  EX_CTRL,
    output logic        LOAD_USE_HAZARD,
    output logic [15:0] BUBBLE_COUNT
);

    // EX slot contents
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_rs1_data;
    logic [31:0] ex_rs2_data;
    logic [31:0] ex_imm;
    logic [4:0]  ex_rs1_addr;
    logic [4:0]  ex_rs2_addr;
    logic [4:0]  ex_rd_addr;
    logic [4:0]  ex_alu_sel;
    logic [1:0]  ex_op_sel;
    logic [2:0]  ex_ctrl;

    logic        fwd_hit_rs1;
    logic        fwd_hit_rs2;
    logic [31:0] fwd_rs1;
    logic [31:0] fwd_rs2;
    logic        bubble_insert;

    // MEM-stage forwarding onto the registered source operands; x0 never forwards
    always_comb begin
        fwd_hit_rs1 = MEM_FWD_EN && (MEM_FWD_RD != 5'd0) && (MEM_FWD_RD == ex_rs1_addr);
        fwd_hit_rs2 = MEM_FWD_EN && (MEM_FWD_RD != 5'd0) && (MEM_FWD_RD == ex_rs2_addr);
        fwd_rs1     = fwd_hit_rs1 ? MEM_FWD_DATA : ex_rs1_data;
        fwd_rs2     = fwd_hit_rs2 ? MEM_FWD_DATA : ex_rs2_data;
    end

    // Load in EX whose result is needed by the instruction in decode
    always_comb begin
        LOAD_USE_HAZARD = ex_valid && ex_ctrl[1] && (ex_rd_addr != 5'd0) && ID_VALID &&
                          ((ex_rd_addr == ID_RS1_ADDR) || (ex_rd_addr == ID_RS2_ADDR));
        bubble_insert   = !FLUSH && !STALL && LOAD_USE_HAZARD;
    end

    // Pipeline register: flush > stall > load-use bubble > capture
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1_addr <= '0;
            ex_rs2_addr <= '0;
            ex_rd_addr  <= '0;
            ex_alu_sel  <= '0;
            ex_op_sel   <= '0;
            ex_ctrl     <= '0;
        end else if (FLUSH) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
        end else if (STALL) begin
            // Latch forwarded data so it survives the producer leaving MEM
            if (fwd_hit_rs1) begin
                ex_rs1_data <= MEM_FWD_DATA;
            end
            if (fwd_hit_rs2) begin
                ex_rs2_data <= MEM_FWD_DATA;
            end
        end else if (LOAD_USE_HAZARD) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
        end else begin
            ex_valid    <= ID_VALID;
            ex_pc       <= ID_PC;
            ex_rs1_data <= ID_RS1_DATA;
            ex_rs2_data <= ID_RS2_DATA;
            ex_imm      <= ID_IMM;
            ex_rs1_addr <= ID_RS1_ADDR;
            ex_rs2_addr <= ID_RS2_ADDR;
            ex_rd_addr  <= ID_RD_ADDR;
            ex_alu_sel  <= ID_ALU_SELECT;
            ex_op_sel   <= ID_OP_SEL;
            ex_ctrl     <= ID_VALID ? ID_CTRL : 3'b000;
        end
    end

    // Operand selection and output gating for the EX stage
    always_comb begin
        EX_VALID      = ex_valid;
        EX_PC         = ex_pc;
        ALU_DATA1     = ex_op_sel[1] ? ex_pc  : fwd_rs1;
        ALU_DATA2     = ex_op_sel[0] ? ex_imm : fwd_rs2;
        EX_STORE_DATA = fwd_rs2;
        ALU_SELECT    = ex_valid ? ex_alu_sel : 5'b00000;
        EX_RD_ADDR    = ex_rd_addr;
        EX_CTRL       = ex_ctrl;
    end

`ifdef ID_EX_PERF_EN
    logic [15:0] bubble_cnt;

    // Saturating count of load-use bubbles actually inserted
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            bubble_cnt <= '0;
        end else if (bubble_insert && (bubble_cnt != 16'hFFFF)) begin
            bubble_cnt <= bubble_cnt + 16'd1;
        end
    end

    assign BUBBLE_COUNT = bubble_cnt;
`else
    logic unused_bubble;

    // Counter not built; keep the insert term referenced
    always_comb begin
        unused_bubble = bubble_insert;
    end

    assign BUBBLE_COUNT = '0;
`endif

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage
Interface
REQ-001 SHALL have port CLK  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have port RESETN  in  1  asynchronous, active-low reset.
REQ-003 SHALL have port STALL  in  1  downstream hold; stage contents held.
REQ-004 SHALL have port FLUSH  in  1  taken branch/jump; kill instruction entering EX.
REQ-005 SHALL have port ID_VALID  in  1  decode slot holds a real instruction.
REQ-006 SHALL have port ID_PC  in  32  PC of decode instruction.
REQ-007 SHALL have port ID_RS1_DATA  in  32  register-file read data, rs1 (WB write-through already applied).
REQ-008 SHALL have port ID_RS2_DATA  in  32  register-file read data, rs2.
REQ-009 SHALL have port ID_IMM  in  32  sign-extended immediate.
REQ-010 SHALL have port ID_RS1_ADDR  in  5  rs1 index.
REQ-011 SHALL have port ID_RS2_ADDR  in  5  rs2 index.
REQ-012 SHALL have port ID_RD_ADDR  in  5  destination index.
REQ-013 SHALL have port ID_ALU_SELECT  in  5  ALU opcode, 5'b00000 FORWARD .. 5'b10010 SLTU.
REQ-014 SHALL have port ID_OP_SEL  in  2  bit1: operand1 = PC; bit0: operand2 = IMM.
REQ-015 SHALL have port ID_CTRL  in  3  {REG_WRITE, MEM_READ, MEM_WRITE}.
REQ-016 SHALL have port MEM_FWD_EN  in  1  MEM stage writes a register.
REQ-017 SHALL have port MEM_FWD_RD  in  5  MEM stage destination index.
REQ-018 SHALL have port MEM_FWD_DATA  in  32  MEM stage result.
REQ-019 SHALL have port EX_VALID  out  1  EX slot holds a real instruction.
REQ-020 SHALL have port EX_PC  out  32  registered PC.
REQ-021 SHALL have port ALU_DATA1  out  32  ALU DATA1 operand.
REQ-022 SHALL have port ALU_DATA2  out  32  ALU DATA2 operand.
REQ-023 SHALL have port ALU_SELECT  out  5  ALU SELECT.
REQ-024 SHALL have port EX_STORE_DATA  out  32  forwarded rs2 for stores.
REQ-025 SHALL have port EX_RD_ADDR  out  5  registered rd.
REQ-026 SHALL have port EX_CTRL  out  3  registered control, zero when EX_VALID=0.
REQ-027 SHALL have port LOAD_USE_HAZARD  out  1  combinational; hazard unit stalls IF/ID.
REQ-028 SHALL have port BUBBLE_COUNT  out  16  bubbles inserted (see Configuration).
Function
REQ-029 Edge priority SHALL be: FLUSH > STALL > LOAD_USE_HAZARD > capture; FLUSH clears EX_VALID and EX_CTRL even when STALL=1.
REQ-030 Capture SHALL load all ID_* fields; EX_VALID <= ID_VALID; EX_CTRL <= ID_VALID ? ID_CTRL : 0.
REQ-031 LOAD_USE_HAZARD SHALL = EX_VALID & EX_CTRL[1] & EX_RD_ADDR!=0 & ID_VALID & (EX_RD_ADDR==ID_RS1_ADDR | EX_RD_ADDR==ID_RS2_ADDR); on it the stage SHALL insert a bubble (EX_VALID=0, EX_CTRL=0), single cycle per hazard.
REQ-032 Forward hit on rsN SHALL = MEM_FWD_EN & MEM_FWD_RD!=0 & MEM_FWD_RD==registered rsN index; hit selects MEM_FWD_DATA, else registered rsN data; index 0 SHALL never forward.
REQ-033 ALU_DATA1 SHALL = OP_SEL[1] ? EX_PC : fwd rs1; ALU_DATA2 SHALL = OP_SEL[0] ? EX_IMM : fwd rs2; EX_STORE_DATA SHALL = fwd rs2; zero added latency (combinational from registers).
REQ-034 ALU_SELECT SHALL be 5'b00000 whenever EX_VALID=0.
REQ-035 While STALL=1 (no FLUSH) every field SHALL hold except registered rs1/rs2 data, which SHALL be overwritten with MEM_FWD_DATA on a forward hit so the value survives MEM retiring.
REQ-036 Latency ID->EX SHALL be exactly one cycle when STALL=0 and no hazard.
Reset
REQ-037 RESETN=0 SHALL immediately clear all registers: EX_VALID=0, EX_PC=0, EX_CTRL=0, EX_RD_ADDR=0, ALU_SELECT=0, operand data 0, BUBBLE_COUNT=0, including mid-stall.
Configuration
REQ-038 With ID_EX_PERF_EN defined, BUBBLE_COUNT SHALL increment by 1 on each edge inserting a load-use bubble, saturating at 16'hFFFF.
REQ-039 Without ID_EX_PERF_EN, BUBBLE_COUNT SHALL be constant 0 and no counter register SHALL exist.
Verification
REQ-040 Capture: ID_VALID=1, rs1=5/0x10, rs2=6/0x3, ALU_SELECT=5'b00001, OP_SEL=00 -> next cycle ALU_DATA1=0x10, ALU_DATA2=0x3, EX_VALID=1.
REQ-041 Forward: EX rs1=7, MEM_FWD_EN=1, MEM_FWD_RD=7, MEM_FWD_DATA=0xAB -> ALU_DATA1=0xAB; same with MEM_FWD_RD=0 and rs1=0 -> registered value.
REQ-042 Load-use: EX load rd=3, ID rs2=3 -> LOAD_USE_HAZARD=1, next cycle EX_VALID=0, ALU_SELECT=0, BUBBLE_COUNT=1 (with ID_EX_PERF_EN).
REQ-043 Stall refresh: STALL=1 two cycles, MEM forwards rd=rs1 data 0x55 in cycle 1 only -> ALU_DATA1 remains 0x55 in cycle 2 and after release.
REQ-044 FLUSH with STALL=1 -> EX_VALID=0, EX_CTRL=0 next edge; RESETN pulse mid-stall -> all outputs 0 without clock edge.
